// File: rtl/pipe_game_ctrl.sv
// Game controller for the flappy-style game: state machine, scrolling pipes with
// LFSR-randomised gaps, bird collision detection and a saturating score.
module pipe_game_ctrl #(
    parameter int          SCREEN_WIDTH  = 640,
    parameter int          SCREEN_HEIGHT = 480,
    parameter int          NUM_PIPES     = 3,
    parameter int          XW            = 11,
    parameter int          PIPE_WIDTH    = 50,
    parameter int          PIPE_GAP      = 100,
    parameter int          PIPE_SPACING  = 220,
    parameter int          SPEED         = 1,
    parameter int          GAP_DEFAULT   = 190,
    parameter int          GAP_MIN       = 40,
    parameter int          BIRD_X        = 100,
    parameter int          BIRD_WIDTH    = 20,
    parameter int          BIRD_HEIGHT   = 20,
    parameter int          SCORE_W       = 8,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tick,
    input  logic                    start_button,
    input  logic [9:0]              bird_y,
    output logic [1:0]              state,
    output logic [NUM_PIPES*XW-1:0] pipe_x,
    output logic [NUM_PIPES*10-1:0] pipe_gap_y,
    output logic [SCORE_W-1:0]      score,
    output logic                    collision,
    output logic                    game_over
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        OVER = 2'b10
    } state_t;

    // Collision arithmetic is done one bit wider than the pipe coordinate so sums never wrap.
    localparam int                CW            = XW + 1;
    localparam int                SW            = SCORE_W + 4;
    localparam logic [CW-1:0]     PIPE_WIDTH_C  = CW'(PIPE_WIDTH);
    localparam logic [CW-1:0]     PIPE_GAP_C    = CW'(PIPE_GAP);
    localparam logic [CW-1:0]     BIRD_X_C      = CW'(BIRD_X);
    localparam logic [CW-1:0]     BIRD_RIGHT_C  = CW'(BIRD_X + BIRD_WIDTH);
    localparam logic [CW-1:0]     BIRD_H_C      = CW'(BIRD_HEIGHT);
    localparam logic [CW-1:0]     SCREEN_H_C    = CW'(SCREEN_HEIGHT);
    localparam logic [XW-1:0]     SPEED_X       = XW'(SPEED);
    localparam logic [XW-1:0]     RESPAWN_X     = XW'(NUM_PIPES * PIPE_SPACING - SPEED);
    localparam logic [9:0]        GAP_DEFAULT_G = 10'(GAP_DEFAULT);
    localparam logic [9:0]        GAP_MIN_G     = 10'(GAP_MIN);
    localparam logic [SCORE_W-1:0] SCORE_MAX    = '1;
    localparam logic [15:0]       LFSR_MASK     = 16'hB400;

    state_t              state_r;
    logic [XW-1:0]       x_r [NUM_PIPES];
    logic [9:0]          gap_r [NUM_PIPES];
    logic [SCORE_W-1:0]  score_r;
    logic                collision_r;
    logic                game_over_r;
    logic                start_prev_r;
    logic [15:0]         lfsr_r;

    logic                start_pulse_s;
    logic                hit_s;
    logic [CW-1:0]       bird_top_s;
    logic [XW-1:0]       x_next_s [NUM_PIPES];
    logic [9:0]          gap_next_s [NUM_PIPES];
    logic [3:0]          cross_cnt_s;
    logic [SW-1:0]       score_sum_s;
    logic [SCORE_W-1:0]  score_next_s;
    logic [15:0]         lfsr_next_s;

    function automatic logic [XW-1:0] init_x(input int idx);
        return XW'(SCREEN_WIDTH + idx * PIPE_SPACING);
    endfunction

    assign start_pulse_s = start_button & ~start_prev_r;
    assign lfsr_next_s   = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? LFSR_MASK : 16'h0000);

    // Bird against every pipe column outside its gap, and against the floor.
    always_comb begin
        bird_top_s = CW'(bird_y);
        hit_s      = (bird_top_s + BIRD_H_C) > SCREEN_H_C;
        for (int i = 0; i < NUM_PIPES; i++) begin
            hit_s = hit_s
                  | ((BIRD_X_C < ({1'b0, x_r[i]} + PIPE_WIDTH_C))
                  &  (BIRD_RIGHT_C > {1'b0, x_r[i]})
                  &  ((bird_top_s < CW'(gap_r[i]))
                  |   ((bird_top_s + BIRD_H_C) > (CW'(gap_r[i]) + PIPE_GAP_C))));
        end
    end

    // Per-tick pipe motion, respawn and the count of pipes just passed by the bird.
    always_comb begin
        cross_cnt_s = 4'd0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (x_r[i] < SPEED_X) begin
                x_next_s[i]   = x_r[i] + RESPAWN_X;
                gap_next_s[i] = GAP_MIN_G + {2'b00, lfsr_r[7:0]};
            end else begin
                x_next_s[i]   = x_r[i] - SPEED_X;
                gap_next_s[i] = gap_r[i];
                if ((({1'b0, x_r[i]} + PIPE_WIDTH_C) >= BIRD_X_C) &&
                    (({1'b0, x_r[i] - SPEED_X} + PIPE_WIDTH_C) < BIRD_X_C)) begin
                    cross_cnt_s = cross_cnt_s + 4'd1;
                end else begin
                    cross_cnt_s = cross_cnt_s;
                end
            end
        end
        score_sum_s  = SW'(score_r) + SW'(cross_cnt_s);
        score_next_s = (score_sum_s > SW'(SCORE_MAX)) ? SCORE_MAX : score_sum_s[SCORE_W-1:0];
    end

    // Game state machine with all pipe, score and flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            score_r      <= '0;
            collision_r  <= 1'b0;
            game_over_r  <= 1'b0;
            start_prev_r <= 1'b0;
            lfsr_r       <= LFSR_SEED;
            for (int i = 0; i < NUM_PIPES; i++) begin
                x_r[i]   <= init_x(i);
                gap_r[i] <= GAP_DEFAULT_G;
            end
        end else begin
            start_prev_r <= start_button;
            lfsr_r       <= lfsr_next_s;
            case (state_r)
                IDLE: begin
                    score_r     <= '0;
                    collision_r <= 1'b0;
                    game_over_r <= 1'b0;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_r[i]   <= init_x(i);
                        gap_r[i] <= GAP_DEFAULT_G;
                    end
                    if (start_pulse_s) begin
                        state_r <= PLAY;
                    end
                end
                PLAY: begin
                    if (hit_s) begin
                        state_r     <= OVER;
                        collision_r <= 1'b1;
                        game_over_r <= 1'b1;
                    end else if (tick) begin
                        score_r <= score_next_s;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            x_r[i]   <= x_next_s[i];
                            gap_r[i] <= gap_next_s[i];
                        end
                    end
                end
                OVER: begin
                    if (start_pulse_s) begin
                        state_r     <= IDLE;
                        score_r     <= '0;
                        collision_r <= 1'b0;
                        game_over_r <= 1'b0;
                        for (int i = 0; i < NUM_PIPES; i++) begin
                            x_r[i]   <= init_x(i);
                            gap_r[i] <= GAP_DEFAULT_G;
                        end
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    score_r     <= '0;
                    collision_r <= 1'b0;
                    game_over_r <= 1'b0;
                    for (int i = 0; i < NUM_PIPES; i++) begin
                        x_r[i]   <= init_x(i);
                        gap_r[i] <= GAP_DEFAULT_G;
                    end
                end
            endcase
        end
    end

    assign state     = state_r;
    assign score     = score_r;
    assign collision = collision_r;
    assign game_over = game_over_r;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pack
        assign pipe_x[g*XW +: XW]   = x_r[g];
        assign pipe_gap_y[g*10 +: 10] = gap_r[g];
    end

endmodule

// File: tb/tb_pipe_game_ctrl.sv
// Bench for pipe_game_ctrl: constant vector table, directed long sequences and
// randomized play compared against a game-rule reference model.
module tb_pipe_game_ctrl;

    localparam int NP = 3;
    localparam int XW = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             tick = 1'b0;
    logic             start_button = 1'b0;
    logic [9:0]       bird_y = 10'd0;
    logic [1:0]       state, state2;
    logic [NP*XW-1:0] pipe_x, pipe_x2;
    logic [NP*10-1:0] gap_y, gap_y2;
    logic [7:0]       score;
    logic [1:0]       score2;
    logic             collision, collision2, game_over, game_over2;

    pipe_game_ctrl dut (
        .clk(clk), .reset(reset), .tick(tick), .start_button(start_button), .bird_y(bird_y),
        .state(state), .pipe_x(pipe_x), .pipe_gap_y(gap_y), .score(score),
        .collision(collision), .game_over(game_over)
    );

    pipe_game_ctrl #(.SCORE_W(2)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .start_button(start_button), .bird_y(bird_y),
        .state(state2), .pipe_x(pipe_x2), .pipe_gap_y(gap_y2), .score(score2),
        .collision(collision2), .game_over(game_over2)
    );

    int total = 0;
    int bad = 0;

    // Reference model: game-level quantities as plain integers.
    int m_state, m_cnt, m_coll, m_lfsr;
    int m_x [NP];
    int m_g [NP];
    bit m_prev;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_init_pipes();
        for (int i = 0; i < NP; i++) begin
            m_x[i] = 640 + 220 * i;
            m_g[i] = 190;
        end
    endtask

    function automatic bit m_hit(int by);
        bit h;
        h = (by + 20 > 480);
        for (int i = 0; i < NP; i++) begin
            // bird columns [100,120) against pipe columns [x, x+50), outside rows [g, g+100]
            if (100 < m_x[i] + 50 && m_x[i] < 120 && (by < m_g[i] || by + 20 > m_g[i] + 100))
                h = 1'b1;
        end
        return h;
    endfunction

    task automatic model_step();
        int nl;
        bit pulse;
        nl = (m_lfsr >> 1) ^ (((m_lfsr & 1) != 0) ? 'hB400 : 0);
        if (reset) begin
            m_state = 0; m_cnt = 0; m_coll = 0; m_lfsr = 'hACE1; m_prev = 1'b0;
            m_init_pipes();
        end else begin
            pulse  = start_button && !m_prev;
            m_prev = start_button;
            case (m_state)
                0: begin
                    m_init_pipes();
                    if (pulse) m_state = 1;
                end
                1: begin
                    if (m_hit(int'(bird_y))) begin
                        m_state = 2;
                        m_coll  = 1;
                    end else if (tick) begin
                        for (int i = 0; i < NP; i++) begin
                            if (m_x[i] < 1) begin
                                m_x[i] = m_x[i] + 3 * 220 - 1;
                                m_g[i] = 40 + (m_lfsr & 255);
                            end else begin
                                if (m_x[i] + 50 >= 100 && m_x[i] - 1 + 50 < 100) m_cnt++;
                                m_x[i] = m_x[i] - 1;
                            end
                        end
                    end
                end
                default: begin
                    if (pulse) begin
                        m_state = 0; m_cnt = 0; m_coll = 0;
                        m_init_pipes();
                    end
                end
            endcase
            m_lfsr = nl;
        end
    endtask

    task automatic compare_model();
        longint ex, eg;
        ex = 0; eg = 0;
        for (int i = 0; i < NP; i++) begin
            ex = ex | (longint'(m_x[i]) << (i * 11));
            eg = eg | (longint'(m_g[i]) << (i * 10));
        end
        check("state", longint'(state), m_state);
        check("game_over", longint'(game_over), (m_state == 2) ? 1 : 0);
        check("collision", longint'(collision), m_coll);
        check("score", longint'(score), (m_cnt > 255) ? 255 : m_cnt);
        check("pipe_x", longint'(pipe_x), ex);
        check("pipe_gap_y", longint'(gap_y), eg);
        check("state_w2", longint'(state2), m_state);
        check("score_w2", longint'(score2), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic step(input bit r, input bit t, input bit s, input int by);
        reset = r; tick = t; start_button = s; bird_y = 10'(by);
        @(posedge clk);
        model_step();
        #1;
        compare_model();
    endtask

    // Bird height that sits inside the gap of whichever pipe currently spans the bird.
    function automatic int guided_y();
        for (int i = 0; i < NP; i++) begin
            if (m_x[i] < 120 && m_x[i] + 50 > 100) return m_g[i] + int'($urandom_range(80, 0));
        end
        return 200;
    endfunction

    typedef struct {
        bit r, t, s;
        int by;
        int st, x0, sc, co;
    } vec_t;

    vec_t tbl [16];
    int   pass_tick [5] = '{591, 811, 1031, 1251, 1471};

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 200, 0, 640, 0, 0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 470, 2, 640, 0, 1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 200, 2, 640, 0, 1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 200, 0, 640, 0, 0};
        tbl[9]  = '{1'b0, 1'b1, 1'b1, 200, 0, 640, 0, 0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 200, 0, 640, 0, 0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 200, 1, 640, 0, 0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 200, 1, 639, 0, 0};
        tbl[13] = '{1'b1, 1'b1, 1'b1, 200, 0, 640, 0, 0};
        tbl[14] = '{1'b0, 1'b1, 1'b0, 200, 0, 640, 0, 0};
        tbl[15] = '{1'b0, 1'b1, 1'b1, 200, 1, 640, 0, 0};

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].s, tbl[i].by);
            check($sformatf("tbl%0d_state", i), longint'(state), tbl[i].st);
            check($sformatf("tbl%0d_x0", i), longint'(pipe_x[10:0]), tbl[i].x0);
            check($sformatf("tbl%0d_score", i), longint'(score), tbl[i].sc);
            check($sformatf("tbl%0d_collision", i), longint'(collision), tbl[i].co);
        end

        // Long scroll with the bird in the default gap: first pass, then respawn.
        step(1'b1, 1'b0, 1'b0, 200);
        step(1'b0, 1'b0, 1'b1, 200);
        for (int k = 1; k <= 641; k++) begin
            step(1'b0, 1'b1, 1'b0, 200);
            if (k == 591) begin
                check("seqA_x0_591", longint'(pipe_x[10:0]), 49);
                check("seqA_score_591", longint'(score), 1);
            end
            if (k == 640) check("seqA_x0_640", longint'(pipe_x[10:0]), 0);
        end
        check("seqA_x0_respawn", longint'(pipe_x[10:0]), 659);
        check("seqA_x2", longint'(pipe_x[32:22]), 439);
        check("seqA_gap0_range", longint'((gap_y[9:0] >= 10'd40) && (gap_y[9:0] <= 10'd295)), 1);
        check("seqA_no_collision", longint'(collision), 0);

        // Bird above the gap collides as the first pipe reaches it.
        step(1'b1, 1'b0, 1'b0, 100);
        step(1'b0, 1'b0, 1'b1, 100);
        for (int k = 1; k <= 521; k++) step(1'b0, 1'b1, 1'b0, 100);
        check("seqB_x0_hit", longint'(pipe_x[10:0]), 119);
        check("seqB_still_play", longint'(state), 1);
        step(1'b0, 1'b1, 1'b0, 100);
        check("seqB_over", longint'(state), 2);
        check("seqB_collision", longint'(collision), 1);
        check("seqB_game_over", longint'(game_over), 1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b0, 100);
        check("seqB_frozen_x0", longint'(pipe_x[10:0]), 119);
        check("seqB_frozen_score", longint'(score), 0);

        // Five passes with a steered bird: narrow score saturates at 3.
        step(1'b1, 1'b0, 1'b0, 200);
        step(1'b0, 1'b0, 1'b1, 200);
        begin
            int p;
            p = 0;
            for (int k = 1; k <= 1471; k++) begin
                step(1'b0, 1'b1, 1'b0, guided_y());
                if (p < 5 && k == pass_tick[p]) begin
                    p++;
                    check($sformatf("seqC_score_pass%0d", p), longint'(score), p);
                    check($sformatf("seqC_score_w2_pass%0d", p), longint'(score2), (p > 3) ? 3 : p);
                end
            end
        end

        // Randomized play, mostly steered through gaps, with random starts and resets.
        for (int k = 0; k < 5000; k++) begin
            bit r, t, s;
            int by;
            r  = ($urandom_range(299, 0) == 0);
            t  = ($urandom_range(1, 0) == 1);
            s  = ($urandom_range(39, 0) == 0);
            by = ($urandom_range(5, 0) != 0) ? guided_y() : int'($urandom_range(470, 0));
            step(r, t, s, by);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_game_ctrl.md
Name: pipe_game_ctrl

Overview:
- Parametrised multi-pipe game controller for the flappy-style game.
- Owns the game state machine, NUM_PIPES scrolling pipes with LFSR-randomised gap heights, bird-vs-pipe and bird-vs-screen collision, and a saturating score counter.
- Pipes advance once per frame strobe.
- Sits between the bird physics block (drives bird_y) and the renderer (consumes pipe positions, score and state).

Parameters:
- SCREEN_WIDTH, 640, visible width in pixels.
- SCREEN_HEIGHT, 480, visible height in pixels.
- NUM_PIPES, 3, number of simultaneous pipes (1..8).
- XW, 11, pipe x-coordinate width; requires SCREEN_WIDTH + NUM_PIPES*PIPE_SPACING < 2**XW.
- PIPE_WIDTH, 50, pipe width in pixels.
- PIPE_GAP, 100, vertical gap height.
- PIPE_SPACING, 220, horizontal distance between successive pipe left edges; must exceed PIPE_WIDTH + BIRD_WIDTH.
- SPEED, 1, pixels moved per tick (1..PIPE_WIDTH).
- GAP_DEFAULT, 190, gap top after reset and in IDLE.
- GAP_MIN, 40, minimum randomised gap top; requires GAP_MIN + 255 + PIPE_GAP < SCREEN_HEIGHT.
- BIRD_X, 100, fixed bird left edge.
- BIRD_WIDTH, 20, bird width.
- BIRD_HEIGHT, 20, bird height.
- SCORE_W, 8, score width.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle frame strobe.
- start_button  in  1  level input, already debounced.
- bird_y  in  10  bird top edge, 0 = top of screen.
- state  out  2  00 IDLE, 01 PLAY, 10 OVER.
- pipe_x  out  NUM_PIPES*XW  pipe left edges; pipe i occupies bits [i*XW +: XW].
- pipe_gap_y  out  NUM_PIPES*10  gap top edges; pipe i occupies bits [i*10 +: 10].
- score  out  SCORE_W  pipes passed.
- collision  out  1  registered collision flag.
- game_over  out  1  high exactly while state==OVER.

Behaviour:
- Reset (synchronous, evaluated before all other logic, any state):
  - state=IDLE.
  - pipe_x[i]=SCREEN_WIDTH+i*PIPE_SPACING.
  - pipe_gap_y[i]=GAP_DEFAULT.
  - score=0, collision=0, game_over=0.
  - lfsr=LFSR_SEED.
  - start edge register=0.
- Start detection: start_pulse = start_button & ~start_prev. start_prev is registered every cycle. Holding the button produces exactly one pulse.
- LFSR: 16-bit Galois, mask 16'hB400, shifts right every cycle in all states.
- IDLE:
  - Pipes, gaps, score and collision are held at their reset values.
  - start_pulse -> PLAY at the next edge.
  - tick is ignored.
- PLAY, hit evaluated combinationally every cycle from the registered pipe state and the current bird_y:
  - Pipe overlap for pipe i, all of: BIRD_X < pipe_x[i]+PIPE_WIDTH, BIRD_X+BIRD_WIDTH > pipe_x[i], and (bird_y < gap_y[i] or bird_y+BIRD_HEIGHT > gap_y[i]+PIPE_GAP).
  - Screen-bound hit: bird_y+BIRD_HEIGHT > SCREEN_HEIGHT.
  - hit = OR of all pipe overlaps and the screen-bound hit.
  - Compute all sums at XW+1 bits; no wrap.
- PLAY with hit:
  - Next edge: state=OVER, collision=1, game_over=1.
  - Pipes and score do not update on that edge, even if tick=1.
- PLAY with tick and no hit, per pipe:
  - If pipe_x < SPEED: respawn with pipe_x <= pipe_x + NUM_PIPES*PIPE_SPACING - SPEED and gap_y <= GAP_MIN + lfsr[7:0]. Exact spacing is preserved.
  - Else: pipe_x <= pipe_x - SPEED.
  - Score: +1 for each pipe whose right edge crosses the bird, i.e. old pipe_x+PIPE_WIDTH >= BIRD_X and new pipe_x+PIPE_WIDTH < BIRD_X (respawning pipes excluded).
  - Score saturates at 2**SCORE_W-1.
- PLAY with no tick and no hit: all registers hold.
- OVER:
  - Pipes, gaps, score and collision are frozen; tick is ignored.
  - start_pulse -> IDLE at the next edge. On that edge score=0, collision=0, and pipes and gaps are reinitialised to reset values (lfsr is not reseeded).
- Latency:
  - Start press to state=PLAY: 1 edge.
  - Hit condition to collision/OVER: 1 edge.
  - tick to updated pipe_x and score: 1 edge.
- state value 11 is illegal; it recovers to IDLE at the next edge.

Test Plan:
- Reset, then press start (held 5 cycles) -> state=01 after 1 edge, one transition only; pipe_x={640,860,1080}, gaps all 190, score=0.
- PLAY, bird_y=200 (inside gap 190..290), 591 ticks -> pipe0 x=49, score=1 on the 591st tick edge. At 640 ticks pipe0 x=0. Tick 641 -> pipe0 x=659, pipe2 x=439, pipe0 gap = 40+lfsr[7:0] (40..295); no collision.
- PLAY, bird_y=100 (above gap) -> hit when pipe0 x=119 (tick 521). Next edge state=10, collision=1, game_over=1. 10 further ticks -> pipe0 stays 119, score unchanged.
- PLAY, bird_y=470 with no ticks -> floor hit, OVER after 1 edge.
- OVER, start held high -> IDLE after 1 edge, score=0, pipes reinitialised, stays IDLE. Release and press again -> PLAY.
- SCORE_W=2: pass 5 pipes -> score 1,2,3,3,3. Reset asserted mid-PLAY -> all reset values at the next edge, regardless of tick or start.
